// File: rtl/bcd_alu.sv
// Two-digit packed-BCD add/subtract unit with a registered result and decimal carry/borrow.
// Invalid BCD digits on either operand force a zero result regardless of opcode.
module bcd_alu #(
  parameter int NUM_DIGITS = 2,
  localparam int W = 4 * NUM_DIGITS
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [1:0]   opcode,
  output logic [W-1:0] result,
  output logic         MSD_c_out
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  logic         w_valid;
  logic [W-1:0] w_sum;
  logic         w_sum_c;
  logic [W-1:0] w_diff;
  logic         w_diff_b;
  logic [4:0]   w_s;
  logic [4:0]   w_s_adj;
  logic         w_carry;
  logic [5:0]   w_d;
  logic [5:0]   w_d_adj;
  logic         w_borrow;
  logic [W-1:0] w_next_result;
  logic         w_next_c;
  logic [W-1:0] r_result;
  logic         r_c_out;

  always_comb begin
    w_valid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (op1[4*i +: 4] > 4'd9 || op2[4*i +: 4] > 4'd9) w_valid = 1'b0;
    end
  end

  // Ripple decimal add: a digit sum above 9 is corrected by +6 and carries on.
  always_comb begin
    w_sum   = '0;
    w_carry = 1'b0;
    w_s     = '0;
    w_s_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_s     = {1'b0, op1[4*i +: 4]} + {1'b0, op2[4*i +: 4]} + {4'b0, w_carry};
      w_s_adj = w_s + 5'd6;
      if (w_s > 5'd9) begin
        w_sum[4*i +: 4] = w_s_adj[3:0];
        w_carry         = 1'b1;
      end else begin
        w_sum[4*i +: 4] = w_s[3:0];
        w_carry         = 1'b0;
      end
    end
    w_sum_c = w_carry;
  end

  // Ripple decimal subtract: a negative digit difference borrows 10 from the next digit.
  always_comb begin
    w_diff   = '0;
    w_borrow = 1'b0;
    w_d      = '0;
    w_d_adj  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_d     = {2'b0, op1[4*i +: 4]} - {2'b0, op2[4*i +: 4]} - {5'b0, w_borrow};
      w_d_adj = w_d + 6'd10;
      if (w_d[5]) begin
        w_diff[4*i +: 4] = w_d_adj[3:0];
        w_borrow         = 1'b1;
      end else begin
        w_diff[4*i +: 4] = w_d[3:0];
        w_borrow         = 1'b0;
      end
    end
    w_diff_b = w_borrow;
  end

  always_comb begin
    w_next_result = '0;
    w_next_c      = 1'b0;
    if (w_valid) begin
      case (opcode)
        OP_PASS: w_next_result = op1;
        OP_ADD: begin
          w_next_result = w_sum;
          w_next_c      = w_sum_c;
        end
        OP_SUB: begin
          w_next_result = w_diff;
          w_next_c      = w_diff_b;
        end
        default: begin
          w_next_result = '0;
          w_next_c      = 1'b0;
        end
      endcase
    end
  end

  // No handshake: the registers capture a new result on every rising edge.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_result <= '0;
      r_c_out  <= 1'b0;
    end else begin
      r_result <= w_next_result;
      r_c_out  <= w_next_c;
    end
  end

  assign result    = r_result;
  assign MSD_c_out = r_c_out;

endmodule

// File: tb/tb_bcd_alu.sv
// Self-checking bench for bcd_alu: directed tables, latency checks and random vectors
// scored against an integer decimal model through an expected-value queue.
module tb_bcd_alu;

  localparam int W = 8;

  logic         clk;
  logic         nrst;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [1:0]   opcode;
  logic [W-1:0] result;
  logic         MSD_c_out;

  logic [W:0] exp_q[$];
  logic [W:0] exp_v;
  int         n_vec;
  int         n_fail;

  // Vector layout: {op1, op2, opcode, carry, result}
  localparam logic [26:0] ADD_V [5] = '{
    {8'h37, 8'h12, 2'b01, 1'b0, 8'h49},
    {8'h15, 8'h05, 2'b01, 1'b0, 8'h20},
    {8'h81, 8'h81, 2'b01, 1'b1, 8'h62},
    {8'h99, 8'h99, 2'b01, 1'b1, 8'h98},
    {8'h90, 8'h10, 2'b01, 1'b1, 8'h00}
  };
  localparam logic [26:0] SUB_V [5] = '{
    {8'h99, 8'h55, 2'b10, 1'b0, 8'h44},
    {8'h95, 8'h95, 2'b10, 1'b0, 8'h00},
    {8'h50, 8'h26, 2'b10, 1'b0, 8'h24},
    {8'h12, 8'h37, 2'b10, 1'b1, 8'h75},
    {8'h00, 8'h01, 2'b10, 1'b1, 8'h99}
  };
  localparam logic [26:0] OP_V [5] = '{
    {8'h42, 8'h17, 2'b00, 1'b0, 8'h42},
    {8'h42, 8'h17, 2'b11, 1'b0, 8'h00},
    {8'h3A, 8'h12, 2'b01, 1'b0, 8'h00},
    {8'h12, 8'h3A, 2'b10, 1'b0, 8'h00},
    {8'hF0, 8'h00, 2'b00, 1'b0, 8'h00}
  };

  bcd_alu #(.NUM_DIGITS(2)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .op1       (op1),
    .op2       (op2),
    .opcode    (opcode),
    .result    (result),
    .MSD_c_out (MSD_c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] opc);
    int  da, db, r;
    logic c;
    if (a[7:4] > 9 || a[3:0] > 9 || b[7:4] > 9 || b[3:0] > 9) return '0;
    da = int'(a[7:4]) * 10 + int'(a[3:0]);
    db = int'(b[7:4]) * 10 + int'(b[3:0]);
    case (opc)
      2'b00: begin r = da; c = 1'b0; end
      2'b01: begin r = da + db; c = (r >= 100); r = r % 100; end
      2'b10: begin r = da - db; c = (r < 0); if (c) r = r + 100; end
      default: return '0;
    endcase
    return {c, 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] opc,
                       input logic [W:0] exp_val);
    op1    = a;
    op2    = b;
    opcode = opc;
    exp_q.push_back(exp_val);
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    drive(8'h37, 8'h12, 2'b01, 9'h000);
    exp_q.push_back(9'h000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({MSD_c_out, result} !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d]: got c=%0b r=%h, expected c=%0b r=%h",
                 i, MSD_c_out, result, exp_v[8], exp_v[7:0]);
      end
    end
    nrst = 1'b0;
    exp_q.push_back({1'b0, 8'h49});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if ({MSD_c_out, result} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_release: got c=%0b r=%h, expected c=%0b r=%h",
               MSD_c_out, result, exp_v[8], exp_v[7:0]);
    end
  endtask

  task automatic test_add();
    logic [26:0] v;
    for (int i = 0; i < 5; i++) begin
      v = ADD_V[i];
      drive(v[26:19], v[18:11], v[10:9], v[8:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({MSD_c_out, result} !== exp_v) begin
        n_fail++;
        $display("FAIL add %h+%h: got c=%0b r=%h, expected c=%0b r=%h",
                 v[26:19], v[18:11], MSD_c_out, result, exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_sub();
    logic [26:0] v;
    for (int i = 0; i < 5; i++) begin
      v = SUB_V[i];
      drive(v[26:19], v[18:11], v[10:9], v[8:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({MSD_c_out, result} !== exp_v) begin
        n_fail++;
        $display("FAIL sub %h-%h: got c=%0b r=%h, expected c=%0b r=%h",
                 v[26:19], v[18:11], MSD_c_out, result, exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_opcode_validity();
    logic [26:0] v;
    for (int i = 0; i < 5; i++) begin
      v = OP_V[i];
      drive(v[26:19], v[18:11], v[10:9], v[8:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({MSD_c_out, result} !== exp_v) begin
        n_fail++;
        $display("FAIL opval op=%b %h,%h: got c=%0b r=%h, expected c=%0b r=%h",
                 v[10:9], v[26:19], v[18:11], MSD_c_out, result, exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  // Before each edge the outputs must still hold the previous vector's answer.
  task automatic test_latency();
    logic [W:0] last_exp;
    logic [7:0] a, b;
    logic [1:0] opc;
    last_exp = {1'b0, 8'h00};
    for (int i = 0; i < 6; i++) begin
      a   = 8'((i * 17 + 3) % 10) | 8'(((i * 7 + 1) % 10) << 4);
      b   = 8'((i * 13 + 5) % 10) | 8'(((i * 3 + 2) % 10) << 4);
      opc = 2'(i % 3);
      drive(a, b, opc, model(a, b, opc));
      #1;
      n_vec++;
      if ({MSD_c_out, result} !== last_exp) begin
        n_fail++;
        $display("FAIL latency_hold[%0d]: got c=%0b r=%h, expected c=%0b r=%h",
                 i, MSD_c_out, result, last_exp[8], last_exp[7:0]);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      last_exp = exp_v;
      n_vec++;
      if ({MSD_c_out, result} !== exp_v) begin
        n_fail++;
        $display("FAIL latency_new[%0d]: got c=%0b r=%h, expected c=%0b r=%h",
                 i, MSD_c_out, result, exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(8'h81, 8'h81, 2'b01, 9'h000);
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    exp_v = exp_q.pop_front();
    n_vec++;
    if ({MSD_c_out, result} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_in_flight: got c=%0b r=%h, expected c=%0b r=%h",
               MSD_c_out, result, exp_v[8], exp_v[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [1:0] opc;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
      else a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
      else b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      opc = 2'($urandom_range(0, 3));
      drive(a, b, opc, model(a, b, opc));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if ({MSD_c_out, result} !== exp_v) begin
        n_fail++;
        $display("FAIL random op=%b %h,%h: got c=%0b r=%h, expected c=%0b r=%h",
                 opc, a, b, MSD_c_out, result, exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    nrst   = 1'b1;
    op1    = '0;
    op2    = '0;
    opcode = '0;
    test_reset();
    test_add();
    test_sub();
    test_opcode_validity();
    test_latency();
    test_reset_in_flight();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_alu.md
Name: bcd_alu

Overview:
- Two-digit packed-BCD arithmetic unit: adds or subtracts two 8-bit BCD operands (tens digit in [7:4], units digit in [3:0]).
- Produces a registered BCD result and a decimal carry/borrow flag out of the most-significant digit.
- Sits between the keypad/operand registers and the 7-segment display driver; output digits feed the display directly.

Parameters:
- NUM_DIGITS, 2, number of BCD digits per operand; data width W = 4*NUM_DIGITS (8 by default); only 2 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nrst  input  1  reset; synchronous, active-high (reset when 1, sampled on rising clk).
- op1  input  W  first operand, packed BCD.
- op2  input  W  second operand, packed BCD.
- opcode  input  2  operation select: 00 pass op1, 01 add, 10 subtract, 11 reserved.
- result  output  W  registered packed-BCD result; [3:0] units (LSD), [7:4] tens (MSD).
- MSD_c_out  output  1  registered carry (add) or borrow (subtract) out of the MSD.

Behaviour:
- Datapath is combinational; result and MSD_c_out are registered. Latency is 1 clock: inputs sampled on rising edge N appear on the outputs after edge N.
- Reset: while nrst=1 at a rising edge, result <= 8'h00 and MSD_c_out <= 0. Reset overrides any operation in flight; the first valid result appears one edge after nrst deasserts.
- The unit recomputes every cycle. There is no handshake and no hold/enable; outputs track the inputs with 1-cycle delay.
- Add (01), per digit from LSD to MSD:
  - s = a + b + cin (5 bits).
  - If s > 9, the digit is s+6 mod 16 and cout=1; otherwise the digit is s and cout=0.
  - LSD cin = 0; MSD cin = LSD cout.
  - MSD_c_out = MSD cout (sum ≥ 100).
- Subtract (10): result = op1 − op2 in decimal.
  - Per digit: d = a − b − bin. If d < 0, the digit is d+10 and bout=1; otherwise bout=0.
  - MSD_c_out = MSD bout.
  - If op1 < op2, result is the ten's complement (100 − |diff|) and MSD_c_out=1.
- Pass (00): result = op1, MSD_c_out = 0.
- Reserved (11): result = 8'h00, MSD_c_out = 0.
- Invalid BCD: if any nibble of op1 or op2 is > 9, for any opcode, result = 8'h00 and MSD_c_out = 0.
- Boundary cases:
  - 99+99 → 8'h98 with carry 1.
  - 00−01 → 8'h99 with borrow 1.
  - x−x → 8'h00 with borrow 0.
  - An LSD carry into MSD 9 must ripple: 90+10 → 8'h00 with carry 1.
- No internal state other than the output registers.

Test Plan:
- Reset: nrst=1 for 2 cycles with op1=8'h37, op2=8'h12, opcode=01 → result=8'h00, MSD_c_out=0. Deassert nrst → 8'h49 one edge later.
- Add without carry: 37+12 (op1=8'h37, op2=8'h12, opcode=01) → result=8'h49, MSD_c_out=0. Add with LSD carry: 15+05 → 8'h20, MSD_c_out=0.
- Add with MSD carry: 81+81 → result=8'h62, MSD_c_out=1. Also 99+99 → 8'h98 with carry 1, and 90+10 → 8'h00 with carry 1.
- Subtract: 99−55 → 8'h44, borrow 0; 95−95 → 8'h00, borrow 0; 50−26 → 8'h24, borrow 0.
- Subtract with borrow: 12−37 → 8'h75, MSD_c_out=1; 00−01 → 8'h99, MSD_c_out=1.
- Opcode/validity: opcode=00 with op1=8'h42 → 8'h42, c_out 0; opcode=11 → 8'h00, c_out 0; op1=8'h3A with opcode=01 → 8'h00, c_out 0. Check 1-cycle latency on every change.
